// File: rtl/neuron_pkg.sv
// Shared Q12.20 constants, default sizes and packer state for the neuron datapath.
package neuron_pkg;

    localparam int DW_DEF    = 32;
    localparam int FRAC_DEF  = 20;
    localparam int LANES_DEF = 8;

    localparam logic [31:0] Q_ONE = 32'h0010_0000;
    localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN = 32'h8000_0000;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } pack_state_e;

endpackage

// File: rtl/q_mul_sat.sv
// Signed fixed-point multiply: full product, optional round-half-up (PRODUCT_ROUND_EN),
// arithmetic shift by FRAC, saturate to DW bits. Combinational, no backpressure.
module q_mul_sat #(
    parameter int DW   = 32,
    parameter int FRAC = 20
) (
    input  logic [DW-1:0] x_i,
    input  logic [DW-1:0] w_i,
    output logic [DW-1:0] y_o,
    output logic          sat_o
);

    localparam int PW = 2 * DW;
    localparam logic signed [PW-1:0] HI = {{(DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [PW-1:0] LO = {{(DW + 1){1'b1}}, {(DW - 1){1'b0}}};
`ifdef PRODUCT_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC - 1);
`else
    localparam logic signed [PW-1:0] RND = '0;
`endif

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;

    always_comb begin
        prod    = PW'($signed(x_i)) * PW'($signed(w_i));
        shifted = (prod + RND) >>> FRAC;
        sat_o   = 1'b0;
        y_o     = shifted[DW-1:0];
        if (shifted > HI) begin
            y_o   = {1'b0, {(DW - 1){1'b1}}};
            sat_o = 1'b1;
        end else if (shifted < LO) begin
            y_o   = {1'b1, {(DW - 1){1'b0}}};
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/neuron_operand_collector.sv
// Multiplies (x,w) pairs, saturates to Q12.20 and packs LANES products per operand vector.
// Latency: completing pair handshake E0 -> out_valid after E2. Backpressure stalls output, packer, product reg, then in_ready.
module neuron_operand_collector
    import neuron_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DW    = DW_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DW-1:0]       in_x,
    input  logic [DW-1:0]       in_w,
    input  logic                in_last,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DW*LANES-1:0] operand,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sat_seen
);

    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

    typedef logic [LANES-1:0][DW-1:0] vec_t;

    logic          rdy_en_q;
    logic          p_valid_q, p_valid_d;
    logic [DW-1:0] p_dat_q, p_dat_d;
    logic          p_last_q, p_last_d;
    logic          sat_q, sat_d;
    pack_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    vec_t          pack_q, pack_d;
    vec_t          out_q, out_d;
    logic          out_valid_q, out_valid_d;

    logic [DW-1:0] prod;
    logic          prod_sat;
    logic          in_hs;
    logic          xfer;
    logic          pk_take;

    q_mul_sat #(.DW(DW), .FRAC(FRAC)) u_mul (
        .x_i   (in_x),
        .w_i   (in_w),
        .y_o   (prod),
        .sat_o (prod_sat)
    );

    // A FULL pack can still accept a product in the cycle it drains: it lands in lane 0 of the fresh vector.
    assign xfer     = (state_q == FULL) && (!out_valid_q || out_ready);
    assign pk_take  = (state_q == FILL) || xfer;
    assign in_ready = rdy_en_q && (!p_valid_q || pk_take);
    assign in_hs    = in_valid && in_ready;

    assign operand   = out_q;
    assign out_valid = out_valid_q;
    assign sat_seen  = sat_q;

    always_comb begin
        p_valid_d   = p_valid_q;
        p_dat_d     = p_dat_q;
        p_last_d    = p_last_q;
        sat_d       = sat_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (in_hs) begin
            p_valid_d = 1'b1;
            p_dat_d   = prod;
            p_last_d  = in_last;
            sat_d     = sat_q | prod_sat;
        end else if (p_valid_q && pk_take) begin
            p_valid_d = 1'b0;
        end

        if (xfer) begin
            out_d       = pack_q;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pack_d  = pack_q;

        case (state_q)
            FILL: begin
                if (p_valid_q) begin
                    pack_d[cnt_q] = p_dat_q;
                    cnt_d         = cnt_q + CW'(1);
                    if (cnt_q == LAST_LANE || p_last_q) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (xfer) begin
                    pack_d  = '0;
                    cnt_d   = '0;
                    state_d = FILL;
                    if (p_valid_q) begin
                        pack_d[0] = p_dat_q;
                        cnt_d     = CW'(1);
                        if (LAST_LANE == '0 || p_last_q) begin
                            state_d = FULL;
                        end
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q    <= 1'b0;
            p_valid_q   <= 1'b0;
            p_dat_q     <= '0;
            p_last_q    <= 1'b0;
            sat_q       <= 1'b0;
            state_q     <= FILL;
            cnt_q       <= '0;
            pack_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rdy_en_q    <= 1'b1;
            p_valid_q   <= p_valid_d;
            p_dat_q     <= p_dat_d;
            p_last_q    <= p_last_d;
            sat_q       <= sat_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pack_q      <= pack_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_neuron_operand_collector.sv
// Directed bench for neuron_operand_collector with a queue-based vector model and literal spot checks.
module tb_neuron_operand_collector;
    import neuron_pkg::*;

    localparam int L = 8;
    typedef logic [32*L-1:0] vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_x = '0;
    logic [31:0] in_w = '0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    vec_t        operand;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        sat_seen;

    neuron_operand_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand   (operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_seen  (sat_seen)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_fail = 0;
    vec_t exp_q[$];
    vec_t cur_v = '0;
    int   cur_n = 0;
    logic sat_m = 1'b0;
    vec_t got_last = '0;
    int   n_vec = 0;
    logic prev_hold = 1'b0;
    vec_t prev_op = '0;
    logic mon_on = 1'b0;
    logic resumed = 1'b0;
    int   ir_low = 0;
    int   stall_after = 0;
    logic [31:0] m_p;
    logic        m_s;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Value-level model: exact product, floor shift, clamp to signed 32-bit.
    function automatic logic [31:0] qmul(input logic [31:0] x, input logic [31:0] w,
                                         output logic s);
        longint a, b, p, q;
        a = longint'($signed(x));
        b = longint'($signed(w));
        p = a * b;
`ifdef PRODUCT_ROUND_EN
        p = p + 64'sd524288;
`endif
        q = p >>> 20;
        s = 1'b0;
        if (q > 64'sd2147483647) begin
            s = 1'b1;
            return 32'h7FFF_FFFF;
        end else if (q < -64'sd2147483648) begin
            s = 1'b1;
            return 32'h8000_0000;
        end
        return q[31:0];
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
            chk("rst_operand", operand, 256'd0);
            chk("rst_in_ready", {255'd0, in_ready}, 256'd0);
            chk("rst_sat_seen", {255'd0, sat_seen}, 256'd0);
            exp_q.delete();
            cur_v = '0;
            cur_n = 0;
            sat_m = 1'b0;
            prev_hold = 1'b0;
        end else begin
            chk("sat_seen", {255'd0, sat_seen}, {255'd0, sat_m});
            if (prev_hold) begin
                chk("hold_valid", {255'd0, out_valid}, 256'd1);
                chk("hold_operand", operand, prev_op);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_vector: got %h required none", operand);
                end else begin
                    chk("vector", operand, exp_q.pop_front());
                end
                got_last = operand;
                n_vec++;
            end
            prev_hold = out_valid && !out_ready;
            prev_op   = operand;
            if (mon_on && in_valid && !in_ready) begin
                ir_low++;
                if (resumed) stall_after++;
            end
            if (in_valid && in_ready) begin
                m_p = qmul(in_x, in_w, m_s);
                sat_m = sat_m | m_s;
                cur_v[32*cur_n +: 32] = m_p;
                cur_n++;
                if (cur_n == L || in_last) begin
                    exp_q.push_back(cur_v);
                    cur_v = '0;
                    cur_n = 0;
                end
            end
        end
    end

    // Presents one pair and returns at #1 after the edge that accepted it.
    task automatic send(input logic [31:0] x, input logic [31:0] w, input logic last);
        int k;
        in_x = x;
        in_w = w;
        in_last = last;
        in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 required 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vec(input int target);
        int k;
        k = 0;
        while (n_vec < target && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        n_chk++;
        if (n_vec < target) begin
            n_fail++;
            $display("FAIL wait_vec_timeout: got %0d vectors required %0d", n_vec, target);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t lit;
        int   base;
        int   k;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("in_ready_before_edge", {255'd0, in_ready}, 256'd0);
        @(posedge clk);
        #1 chk("in_ready_after_edge", {255'd0, in_ready}, 256'd1);

        // 1.0 * 1.5 into every lane, latency pinned edge by edge.
        for (int i = 0; i < L; i++) send(Q_ONE, 32'h0018_0000, 1'b0);
        in_valid = 1'b0;
        chk("lat_E0", {255'd0, out_valid}, 256'd0);
        @(posedge clk);
        #1 chk("lat_E1", {255'd0, out_valid}, 256'd0);
        @(posedge clk);
        #1 chk("lat_E2", {255'd0, out_valid}, 256'd1);
        lit = {8{32'h0018_0000}};
        chk("ones_x_1p5", operand, lit);
        @(posedge clk);
        #1 chk("valid_one_cycle", {255'd0, out_valid}, 256'd0);
        chk("no_sat_yet", {255'd0, sat_seen}, 256'd0);

        // Positive saturation with in_last on lane 0.
        base = n_vec;
        send(32'h7FF0_0000, 32'h0020_0000, 1'b1);
        in_valid = 1'b0;
        wait_vec(base + 1);
        chk("sat_lane", got_last, 256'h7FFF_FFFF);
        chk("sat_seen_set", {255'd0, sat_seen}, 256'd1);

        base = n_vec;
        send(32'hFFF0_0000, 32'h0008_0000, 1'b1);
        in_valid = 1'b0;
        wait_vec(base + 1);
        chk("neg_half", got_last, 256'hFFF8_0000);
        chk("sat_sticky", {255'd0, sat_seen}, 256'd1);

        base = n_vec;
        send(32'h0000_0001, 32'h0008_0000, 1'b1);
        in_valid = 1'b0;
        wait_vec(base + 1);
`ifdef PRODUCT_ROUND_EN
        chk("round_half", got_last, 256'h1);
`else
        chk("trunc_half", got_last, 256'h0);
`endif

        // Partial vector of three, then a fresh vector must restart at lane 0.
        base = n_vec;
        send(Q_ONE, 32'h0010_0000, 1'b0);
        send(Q_ONE, 32'h0020_0000, 1'b0);
        send(Q_ONE, 32'h0030_0000, 1'b1);
        send(Q_ONE, 32'h0040_0000, 1'b1);
        in_valid = 1'b0;
        wait_vec(base + 2);
        chk("restart_lane0", got_last, 256'h0040_0000);

        // in_last on the final lane behaves as a plain full vector.
        base = n_vec;
        for (int i = 0; i < L; i++) send(32'h0020_0000, Q_ONE, i == L - 1);
        in_valid = 1'b0;
        wait_vec(base + 1);
        lit = {8{32'h0020_0000}};
        chk("last_on_lane7", got_last, lit);

        // 24-pair stream with a 10-cycle out_ready stall.
        base = n_vec;
        mon_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 24; i++) send(32'(i + 1) << 20, Q_ONE, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b1;
                resumed = 1'b1;
            end
        join
        mon_on = 1'b0;
        resumed = 1'b0;
        wait_vec(base + 3);
        chk("stream_vectors", 256'(n_vec - base), 256'd3);
        chk("in_ready_dropped", {255'd0, ir_low > 0}, 256'd1);
        chk("no_bubble_after_resume", 256'(stall_after), 256'd0);
        chk("stream_lane7", {224'd0, got_last[32*7 +: 32]}, 256'h0180_0000);

        // Reset with a held vector and a partial pack.
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) send(Q_ONE, Q_ONE, 1'b0);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk);
            #1 k++;
        end
        chk("held_before_reset", {255'd0, out_valid}, 256'd1);
        rst_n = 1'b0;
        #1 chk("reset_out_valid", {255'd0, out_valid}, 256'd0);
        chk("reset_operand", operand, 256'd0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base = n_vec;
        send(Q_ONE, 32'h0050_0000, 1'b1);
        in_valid = 1'b0;
        wait_vec(base + 1);
        chk("after_reset_vec", got_last, 256'h0050_0000);
        chk("after_reset_sat", {255'd0, sat_seen}, 256'd0);

        repeat (5) @(posedge clk);
        #1 chk("model_drained", 256'(exp_q.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_operand_collector.md
Name: neuron_operand_collector

Overview:
- Upstream neighbour of adder_tree. Takes a stream of (input, weight) pairs in signed Q12.20 fixed point and multiplies each pair.
- Each product is saturated back to Q12.20 and packed into LANES lanes. The packed vector is presented as the 256-bit operand bus that adder_tree sums to one neuron pre-activation.
- Valid/ready handshake on both sides; sustains 1 pair/cycle when downstream is ready.

Parameters:
- LANES, 8, number of 32-bit lanes per vector (operand width = 32*LANES).
- DW, 32, lane/sample width in bits.
- FRAC, 20, fractional bits of the Q format.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_x  in  DW  signed Q12.20 neuron input.
- in_w  in  DW  signed Q12.20 weight.
- in_last  in  1  final pair of a partial vector; flush with zero-padding.
- in_valid  in  1  pair valid.
- in_ready  out  1  pair accepted when in_valid && in_ready.
- operand  out  DW*LANES  packed products; lane k = operand[DW*k +: DW].
- out_valid  out  1  operand valid.
- out_ready  in  1  downstream consumes when out_valid && out_ready.
- sat_seen  out  1  sticky: some product saturated since reset.

Behaviour:
- Reset (async, rst_n low) values:
  - in_ready=0 while in reset, 1 from the first edge after release.
  - operand=0, out_valid=0, sat_seen=0.
  - Lane counter=0, all internal valids=0.
- Stage 1, product register:
  - On handshake, compute 64-bit signed x*w.
  - Arithmetic shift right by FRAC (truncate toward -inf).
  - If result > 2^31-1 clamp to 0x7FFFFFFF; if < -2^31 clamp to 0x80000000, and in both cases set sat_seen.
  - Register the result with its in_last flag.
- Stage 2, packer, with states FILL and FULL:
  - FILL: a valid product writes lane[cnt] and cnt increments.
  - If cnt==LANES-1 or the product carries last, go to FULL.
  - FULL: pack contents are moved to the output register when out_valid==0 or out_ready==1 in the same cycle. Then clear the pack register to 0, set cnt=0 and return to FILL.
  - Lanes never written in a vector are 0 (zero padding for in_last).
- Output register: operand and out_valid are held stable while out_valid && !out_ready.
- Flow control:
  - in_ready = !p_valid || packer can take the product this cycle.
  - The packer can take it in FILL, or in FULL when the transfer occurs in the same cycle (write goes to a fresh, zeroed vector, lane 0).
  - No pair is ever dropped or duplicated.
- Latency: handshake of the completing pair at edge E0 → lane written and FULL at E1 → out_valid=1 after E2 (if the output register is free).
- Boundaries:
  - in_last on lane LANES-1: identical to a normal full vector.
  - in_last on lane 0: vector containing one product, other lanes 0.
  - Back-pressure chain: output held, pack FULL, product register held, in_ready=0. Resumes with no bubble when out_ready rises.
  - Reset mid-vector discards partial data.
  - sat_seen is cleared only by reset.

Optional Feature:
- Macro PRODUCT_ROUND_EN.
- Defined: add 2^(FRAC-1) to the 64-bit product before the shift (round half up), then saturate.
- Undefined: plain truncation as above.
- Latency unchanged either way.

Decomposition:
- Shared package neuron_pkg holds:
  - DW, FRAC, LANES defaults.
  - Q-format constants: Q_ONE=0x00100000, Q_MAX=0x7FFFFFFF, Q_MIN=0x80000000.
  - Packer state enum {FILL, FULL}.
- One natural sub-module, q_mul_sat: combinational multiply, shift, optional round, saturate, plus saturation flag. Reused by later neuron stages.

Test Plan:
- Eight pairs, all x=0x00100000 (1.0), w=0x00180000 (1.5), out_ready=1 → one vector, every lane 0x00180000; out_valid for 1 cycle; sat_seen=0.
- x=0x7FF00000 (2047.0), w=0x00200000 (2.0) → lane 0x7FFFFFFF, sat_seen=1 and stays 1.
- x=0xFFF00000 (-1.0), w=0x00080000 (0.5) → lane 0xFFF80000.
- Rounding: x=0x00000001, w=0x00080000 → lane 0 without PRODUCT_ROUND_EN, 0x00000001 with it.
- Three pairs then in_last on the 3rd (products 1.0, 2.0, 3.0) → lanes 0..2 = 0x00100000, 0x00200000, 0x00300000; lanes 3..7 = 0. Next vector starts at lane 0.
- Continuous in_valid for 24 pairs with out_ready low for 10 cycles mid-stream:
  - in_ready drops; operand is held stable.
  - Exactly 3 vectors emerge in order with no loss.
  - Throughput returns to 1 pair/cycle after out_ready=1.
  - Assert rst_n low mid-vector → out_valid=0, operand=0 immediately.
